dsc_mul_ctrl: RTL and testbench
===============================

Name: dsc_mul_ctrl

Overview:
Sequencer for one 4-input deterministic stochastic multiplier datapath (SNG chain, AND, stoch2bin counter). It does the following:
- Accepts an operand set over a valid/ready handshake.
- Holds the operands and clears the datapath, then enables it until overflow/early-shutoff.
- Captures the binary product and presents it over a second valid/ready handshake.
It sits between the operand source (host/FIFO) and the multiplier instance, and owns that instance's en/clear.

Parameters:
SNG_WIDTH, 6, bit width of each operand
NUM_INPUTS, 4, number of operands (fixed to 4 in this block)
PROD_W, NUM_INPUTS*SNG_WIDTH, width of product/result
CNT_W, PROD_W+1, width of run-cycle counter

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-low reset (all state cleared when rst==0 at posedge clk)
in_valid  in  1  operand set valid
in_ready  out  1  controller can accept operands
in_ops  in  PROD_W  packed operands {d,c,b,a}, a in LSBs
mul_a, mul_b, mul_c, mul_d  out  SNG_WIDTH each  registered operands to datapath
mul_clr  out  1  active-high datapath clear pulse
mul_en  out  1  datapath enable
mul_z  in  PROD_W  datapath stoch2bin count
mul_ov  in  1  datapath done/early-shutoff flag
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  PROD_W  captured product
res_cycles  out  CNT_W  number of RUN cycles taken
res_timeout  out  1  result ended by cycle limit, not mul_ov

Behaviour:
- Reset values: in_ready=0 during reset, 1 the cycle after. All other outputs are 0: res_valid, res_data, res_cycles, res_timeout, mul_en, mul_clr, mul_a..d. State is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_ops into mul_a..d and go to CLEAR.
- CLEAR (1 cycle):
  - in_ready=0, mul_clr=1, mul_en=0.
  - Cycle counter zeroed.
  - Go to RUN.
- RUN:
  - mul_en=1; counter increments each cycle.
  - mul_ov is ignored in the first RUN cycle, because the datapath counters are still settling after the clear.
  - From the second RUN cycle, mul_ov==1 → DRAIN, with res_timeout cleared.
  - Counter == 2^PROD_W → DRAIN with res_timeout=1. This is a safety limit; the datapath never needs more cycles.
  - If both conditions occur in the same cycle, mul_ov wins (timeout=0).
- DRAIN (1 cycle):
  - mul_en=0; lets the registered stoch2bin count settle.
  - Capture res_data=mul_z and res_cycles=counter.
  - Go to DONE.
- DONE:
  - res_valid=1; res_data, res_cycles and res_timeout are held stable.
  - On res_ready → IDLE, with res_valid deasserted the next cycle.
  - in_ready stays 0 until back in IDLE; there is no input/output overlap.
- mul_a..d are held constant from accept until return to IDLE.
- Reset mid-operation: immediate return to IDLE next edge, with all outputs at reset values. Any in-flight result is discarded.
- Latency from accept to res_valid = 1 (CLEAR) + N_run + 1 (DRAIN) + 1 cycles.

Optional Feature:
Macro: DSC_CTRL_ZERO_SKIP_EN
- Defined: if any operand is 0 at accept, skip CLEAR/RUN/DRAIN and go straight to DONE next cycle with res_data=0, res_cycles=0, res_timeout=0. mul_en and mul_clr are never asserted for that operand set.
- Undefined: zero operands run the normal sequence; the datapath produces 0 via its early shutoff.

Decomposition:
- Shared package dsc_pkg holds:
  - SNG_WIDTH and NUM_INPUTS defaults.
  - The state enum (IDLE, CLEAR, RUN, DRAIN, DONE).
  - The PROD_W/CNT_W derivations.
- One natural sub-module: dsc_run_counter (CNT_W up-counter with sync clear, enable and limit-reached flag).
- The FSM and handshake registers stay in dsc_mul_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → in_ready=0 and res_valid=0 throughout. After release, in_ready=1 next cycle.
- Operands a=5, b=3, c=2, d=7 with the real multiplier attached → single mul_clr pulse, then mul_en asserted until mul_ov; res_data=210, res_timeout=0.
- Operands a=b=c=d=63 → res_data=15752961. res_cycles equals the number of mul_en cycles counted by the bench.
- Backpressure: res_ready=0 for 10 cycles after res_valid → res_data/res_cycles stable and in_ready=0. Raise res_ready → res_valid low and in_ready high the following cycle.
- Timeout: bench model holds mul_ov=0 → DRAIN after exactly 2^PROD_W RUN cycles, res_timeout=1. Second case: mul_ov rises on the limit cycle → res_timeout=0.
- Mid-run reset: drop rst for 1 cycle during RUN → mul_en=0 next cycle, state IDLE, no res_valid. With DSC_CTRL_ZERO_SKIP_EN, operand b=0 → res_valid 1 cycle after accept, res_data=0, mul_en never high.

Source files
------------

// File: rtl/dsc_pkg.sv
// dsc_pkg
// Shared definitions for the deterministic stochastic multiplier controller:
// default operand width and count, the derived product / run-counter widths,
// and the controller state encoding.
package dsc_pkg;

  localparam int DSC_SNG_WIDTH  = 6;
  localparam int DSC_NUM_INPUTS = 4;

  // Product of NUM_INPUTS operands of sng_width bits each.
  function automatic int dsc_prod_w(input int sng_width, input int num_inputs);
    return sng_width * num_inputs;
  endfunction

  // One extra bit so the counter can hold 2^prod_w itself.
  function automatic int dsc_cnt_w(input int prod_w);
    return prod_w + 1;
  endfunction

  localparam int DSC_PROD_W = dsc_prod_w(DSC_SNG_WIDTH, DSC_NUM_INPUTS);
  localparam int DSC_CNT_W  = dsc_cnt_w(DSC_PROD_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } dsc_state_e;

endpackage

// File: rtl/dsc_run_counter.sv
// dsc_run_counter
// Up-counter of RUN cycles with synchronous clear and count enable.
// Ports:
//   clk     - clock
//   rst     - synchronous active-low reset
//   clr     - synchronous clear to zero
//   en      - count enable
//   cnt     - current count
//   at_last - cnt equals LAST, i.e. the enabled cycle now in progress is
//             the (LAST+1)-th one and therefore the final permitted cycle
module dsc_run_counter #(
  parameter int               CNT_W = 25,
  parameter logic [CNT_W-1:0] LAST  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_last
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_last = (cnt == LAST);

endmodule

// File: rtl/dsc_mul_ctrl.sv
// dsc_mul_ctrl
// Sequencer for one 4-input deterministic stochastic multiplier datapath.
// Accepts an operand set, clears and then enables the datapath until it
// signals done (mul_ov) or the 2^PROD_W cycle safety limit is hit, captures
// the product and presents it on a result handshake.
// Optional build macro: DSC_CTRL_ZERO_SKIP_EN -- an operand set containing a
// zero operand bypasses the datapath and completes immediately with 0.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   in_valid/in_ready   - operand handshake; in_ops = {d,c,b,a}, a in LSBs
//   mul_a..mul_d        - operands held for the datapath
//   mul_clr, mul_en     - datapath clear pulse and enable
//   mul_z, mul_ov       - datapath count and done/early-shutoff flag
//   res_valid/res_ready - result handshake
//   res_data            - captured product
//   res_cycles          - number of RUN cycles taken
//   res_timeout         - run ended by the cycle limit rather than mul_ov
module dsc_mul_ctrl
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH  = DSC_SNG_WIDTH,
  parameter int NUM_INPUTS = DSC_NUM_INPUTS,
  parameter int PROD_W     = dsc_prod_w(SNG_WIDTH, NUM_INPUTS),
  parameter int CNT_W      = dsc_cnt_w(PROD_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PROD_W-1:0]    in_ops,
  output logic [SNG_WIDTH-1:0] mul_a,
  output logic [SNG_WIDTH-1:0] mul_b,
  output logic [SNG_WIDTH-1:0] mul_c,
  output logic [SNG_WIDTH-1:0] mul_d,
  output logic                 mul_clr,
  output logic                 mul_en,
  input  logic [PROD_W-1:0]    mul_z,
  input  logic                 mul_ov,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [PROD_W-1:0]    res_data,
  output logic [CNT_W-1:0]     res_cycles,
  output logic                 res_timeout
);

  // Counter value at the start of the 2^PROD_W-th RUN cycle.
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'({PROD_W{1'b1}});

  dsc_state_e       state_q, state_d;
  logic             accept;
  logic             skip;
  logic             ov_ok;
  logic             run_exit;
  logic             run_last;
  logic [CNT_W-1:0] run_cnt;

  dsc_run_counter #(
    .CNT_W (CNT_W),
    .LAST  (RUN_LAST)
  ) u_run_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (mul_clr),
    .en      (mul_en),
    .cnt     (run_cnt),
    .at_last (run_last)
  );

  assign accept = in_valid && in_ready;

`ifdef DSC_CTRL_ZERO_SKIP_EN
  always_comb begin
    skip = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (in_ops[i*SNG_WIDTH +: SNG_WIDTH] == '0) skip = 1'b1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // The first RUN cycle has run_cnt == 0; mul_ov is not trusted there
  // because the datapath counters are still settling after the clear.
  assign ov_ok    = mul_ov && (run_cnt != '0);
  assign run_exit = ov_ok || run_last;

  // in_ready is registered so it stays low throughout reset and rises
  // only on the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == ST_IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_clr   = 1'b0;
    mul_en    = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = skip ? ST_DONE : ST_CLEAR;
      end
      ST_CLEAR: begin
        mul_clr = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        mul_en = 1'b1;
        if (run_exit) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mul_a       <= '0;
      mul_b       <= '0;
      mul_c       <= '0;
      mul_d       <= '0;
      res_data    <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (accept) begin
        mul_a <= in_ops[0*SNG_WIDTH +: SNG_WIDTH];
        mul_b <= in_ops[1*SNG_WIDTH +: SNG_WIDTH];
        mul_c <= in_ops[2*SNG_WIDTH +: SNG_WIDTH];
        mul_d <= in_ops[3*SNG_WIDTH +: SNG_WIDTH];
        if (skip) begin
          res_data    <= '0;
          res_cycles  <= '0;
          res_timeout <= 1'b0;
        end
      end
      // mul_ov takes priority over the limit when both hit together.
      if (state_q == ST_RUN && run_exit) res_timeout <= !ov_ok;
      // DRAIN gives the datapath's registered count one cycle to settle.
      if (state_q == ST_DRAIN) begin
        res_data   <= mul_z;
        res_cycles <= run_cnt;
      end
    end
  end

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// tb_dsc_mul_ctrl
// Self-checking bench for dsc_mul_ctrl. A default-width instance covers
// reset, products, backpressure, zero operands and mid-run reset; a narrow
// instance (SNG_WIDTH=2, limit 256 cycles) covers the cycle-limit cases.
// Each instance drives a behavioural datapath that raises mul_ov once a
// chosen number of enabled cycles has elapsed and then shows the product.
module tb_dsc_mul_ctrl;

  localparam int SW      = 6;
  localparam int PW      = 24;
  localparam int CW      = 25;
  localparam int LIMIT   = 1 << PW;
  localparam int SW_S    = 2;
  localparam int PW_S    = 8;
  localparam int CW_S    = 9;
  localparam int LIMIT_S = 1 << PW_S;
`ifdef DSC_CTRL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [23:0] data;
    int          cycles;
    bit          tmo;
    int          due;
    int          en;
    int          clr;
    int          hold;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // ---------------- main instance ----------------
  logic          rst, in_valid, in_ready;
  logic [PW-1:0] in_ops;
  logic [SW-1:0] mul_a, mul_b, mul_c, mul_d;
  logic          mul_clr, mul_en, mul_ov;
  logic [PW-1:0] mul_z;
  logic          res_valid, res_ready;
  logic [PW-1:0] res_data;
  logic [CW-1:0] res_cycles;
  logic          res_timeout;

  dsc_mul_ctrl u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_clr(mul_clr), .mul_en(mul_en), .mul_z(mul_z), .mul_ov(mul_ov),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cycles(res_cycles), .res_timeout(res_timeout)
  );

  int            dp_cnt = 0;
  int            dp_len = 1000;
  logic [PW-1:0] dp_prod;
  always @(posedge clk) begin
    if (mul_clr === 1'b1) dp_cnt <= 0;
    else if (mul_en === 1'b1) dp_cnt <= dp_cnt + 1;
  end
  always_comb dp_prod = PW'(mul_a) * PW'(mul_b) * PW'(mul_c) * PW'(mul_d);
  assign mul_ov = (dp_cnt + 1 >= dp_len);
  assign mul_z  = (dp_cnt >= dp_len) ? dp_prod : PW'(dp_cnt);

  // ---------------- narrow instance ----------------
  logic            rst_s, in_valid_s, in_ready_s;
  logic [PW_S-1:0] in_ops_s;
  logic [SW_S-1:0] mul_a_s, mul_b_s, mul_c_s, mul_d_s;
  logic            mul_clr_s, mul_en_s, mul_ov_s;
  logic [PW_S-1:0] mul_z_s;
  logic            res_valid_s, res_ready_s;
  logic [PW_S-1:0] res_data_s;
  logic [CW_S-1:0] res_cycles_s;
  logic            res_timeout_s;

  dsc_mul_ctrl #(.SNG_WIDTH(SW_S)) u_dut_s (
    .clk(clk), .rst(rst_s), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_ops(in_ops_s),
    .mul_a(mul_a_s), .mul_b(mul_b_s), .mul_c(mul_c_s), .mul_d(mul_d_s),
    .mul_clr(mul_clr_s), .mul_en(mul_en_s), .mul_z(mul_z_s), .mul_ov(mul_ov_s),
    .res_valid(res_valid_s), .res_ready(res_ready_s), .res_data(res_data_s),
    .res_cycles(res_cycles_s), .res_timeout(res_timeout_s)
  );

  int              dp_cnt_s = 0;
  int              dp_len_s = 1000;
  logic [PW_S-1:0] dp_prod_s;
  always @(posedge clk) begin
    if (mul_clr_s === 1'b1) dp_cnt_s <= 0;
    else if (mul_en_s === 1'b1) dp_cnt_s <= dp_cnt_s + 1;
  end
  always_comb dp_prod_s = PW_S'(mul_a_s) * PW_S'(mul_b_s) * PW_S'(mul_c_s) * PW_S'(mul_d_s);
  assign mul_ov_s = (dp_cnt_s + 1 >= dp_len_s);
  assign mul_z_s  = (dp_cnt_s >= dp_len_s) ? dp_prod_s : PW_S'(dp_cnt_s);

  // ---------------- checking helpers and reference model ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Run length: mul_ov is honoured from the 2nd RUN cycle, so a datapath
  // that is ready after L cycles finishes after max(L,2); beyond the limit
  // the run is cut off with timeout set and the datapath shows its partial
  // count instead of the product.
  function automatic exp_t predict(input int a, input int b, input int c, input int d,
                                   input int len, input int limit, input int pw,
                                   input int now, input int hold);
    exp_t   e;
    longint prod, v;
    int     k;
    prod   = longint'(a) * longint'(b) * longint'(c) * longint'(d);
    e.hold = hold;
    if (SKIP && (a == 0 || b == 0 || c == 0 || d == 0)) begin
      e.data = '0; e.cycles = 0; e.tmo = 1'b0; e.due = now + 1; e.en = 0; e.clr = 0;
      return e;
    end
    k = (len < 2) ? 2 : len;
    if (k <= limit) begin e.cycles = k;     e.tmo = 1'b0; end
    else            begin e.cycles = limit; e.tmo = 1'b1; end
    v      = (e.cycles >= len) ? prod : longint'(e.cycles);
    v      = v & ((longint'(1) << pw) - 1);
    e.data = 24'(v);
    e.due  = now + e.cycles + 3;
    e.en   = e.cycles;
    e.clr  = 1;
    return e;
  endfunction

  // ---------------- main scoreboard monitor ----------------
  exp_t          exp_q[$];
  exp_t          cur;
  int            en_seen = 0, clr_seen = 0, hold_left = 0;
  bit            in_result = 1'b0, hs_prev = 1'b0;
  logic [PW-1:0] held_data;
  logic [CW-1:0] held_cycles;
  logic          held_tmo;

  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (hs_prev) begin
        chk("release_res_valid", res_valid, 0);
        chk("release_in_ready", in_ready, 1);
        hs_prev = 1'b0;
      end
      if (mul_en === 1'b1)  en_seen++;
      if (mul_clr === 1'b1) clr_seen++;
      if (res_valid === 1'b1) begin
        if (!in_result) begin
          in_result = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", res_valid, 0);
            hold_left = 0;
          end else begin
            cur = exp_q.pop_front();
            chk("res_data", res_data, cur.data);
            chk("res_cycles", res_cycles, cur.cycles);
            chk("res_timeout", res_timeout, cur.tmo);
            chk("latency", cyc, cur.due);
            chk("mul_en_cycles", en_seen, cur.en);
            chk("mul_clr_pulses", clr_seen, cur.clr);
            chk("res_cycles_vs_en", res_cycles, en_seen);
            hold_left = cur.hold;
          end
          held_data = res_data; held_cycles = res_cycles; held_tmo = res_timeout;
          en_seen = 0; clr_seen = 0;
        end else begin
          chk("hold_res_data", res_data, held_data);
          chk("hold_res_cycles", res_cycles, held_cycles);
          chk("hold_res_timeout", res_timeout, held_tmo);
          chk("hold_in_ready", in_ready, 0);
        end
        if (hold_left == 0) begin
          res_ready = 1'b1; hs_prev = 1'b1; in_result = 1'b0;
        end else begin
          res_ready = 1'b0; hold_left--;
        end
      end else begin
        res_ready = 1'b0;
      end
    end
  end

  // ---------------- narrow-instance scoreboard monitor ----------------
  exp_t exp_q_s[$];
  exp_t cur_s;
  int   en_seen_s = 0;
  bit   prev_v_s = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mul_en_s === 1'b1) en_seen_s++;
      if (res_valid_s === 1'b1 && !prev_v_s) begin
        if (exp_q_s.size() == 0) begin
          chk("s_unexpected_result", res_valid_s, 0);
        end else begin
          cur_s = exp_q_s.pop_front();
          chk("s_res_data", res_data_s, cur_s.data);
          chk("s_res_cycles", res_cycles_s, cur_s.cycles);
          chk("s_res_timeout", res_timeout_s, cur_s.tmo);
          chk("s_latency", cyc, cur_s.due);
          chk("s_mul_en_cycles", en_seen_s, cur_s.en);
        end
        en_seen_s = 0;
      end
      prev_v_s = (res_valid_s === 1'b1);
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input int a, input int b, input int c, input int d,
                      input int len, input int hold);
    int t = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    chk("accept_wait", in_ready, 1);
    if (in_ready !== 1'b1) return;
    dp_len   = len;
    in_ops   = {SW'(d), SW'(c), SW'(b), SW'(a)};
    in_valid = 1'b1;
    exp_q.push_back(predict(a, b, c, d, len, LIMIT, PW, cyc, hold));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_s(input int a, input int b, input int c, input int d, input int len);
    int t = 0;
    @(negedge clk);
    while (in_ready_s !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    chk("s_accept_wait", in_ready_s, 1);
    if (in_ready_s !== 1'b1) return;
    dp_len_s   = len;
    in_ops_s   = {SW_S'(d), SW_S'(c), SW_S'(b), SW_S'(a)};
    in_valid_s = 1'b1;
    exp_q_s.push_back(predict(a, b, c, d, len, LIMIT_S, PW_S, cyc, 0));
    @(negedge clk);
    in_valid_s = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || in_result) && t < 5000) begin @(negedge clk); t++; end
    chk("drain_main", exp_q.size(), 0);
  endtask

  task automatic wait_idle_s();
    int t = 0;
    while (exp_q_s.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    chk("drain_narrow", exp_q_s.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic seen_v;
    rst = 1'b0; rst_s = 1'b0;
    in_valid = 1'b1; in_ops = 24'h5A5A5A;
    in_valid_s = 1'b0; in_ops_s = '0; res_ready_s = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_mul_en", mul_en, 0);
      chk("rst_mul_clr", mul_clr, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_cycles", res_cycles, 0);
    end
    rst = 1'b1; rst_s = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    en_seen = 0; clr_seen = 0;

    send(5, 3, 2, 7, 8, 0);          // 210
    send(63, 63, 63, 63, 5, 2);      // 15752961
    send(9, 4, 11, 2, 1, 0);         // mul_ov in first RUN cycle is ignored
    send(12, 1, 7, 3, 6, 10);        // 10 cycles of backpressure
    send(5, 0, 4, 4, 6, 1);          // zero operand
    for (int i = 0; i < 16; i++) begin
      int op[4];
      for (int j = 0; j < 4; j++)
        op[j] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      send(op[0], op[1], op[2], op[3], int'($urandom_range(1, 12)), int'($urandom_range(0, 3)));
    end
    wait_idle();

    // Reset in the middle of a run discards the operation.
    send(7, 7, 7, 7, 40, 0);
    repeat (4) @(negedge clk);
    chk("midrun_mul_en", mul_en, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_mul_en", mul_en, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_mul_a", mul_a, 0);
    exp_q.delete();
    en_seen = 0; clr_seen = 0; in_result = 1'b0; hs_prev = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("midrst_idle_in_ready", in_ready, 1);
    seen_v = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen_v = seen_v | (res_valid !== 1'b0);
    end
    chk("no_result_after_reset", seen_v, 0);
    send(2, 3, 4, 5, 4, 0);
    wait_idle();

    // Cycle limit on the narrow instance (limit = 256 RUN cycles).
    send_s(3, 2, 1, 3, 100000);      // never done -> timeout
    send_s(3, 2, 1, 3, 256);         // done on the limit cycle -> no timeout
    send_s(1, 3, 1, 1, 255);         // done one cycle early
    wait_idle_s();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
